// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter sharing the CPU Avalon-MM master between fetch and data.
// Grant is held for a whole transfer; long stalls raise a sticky timeout flag.
module mips_cpu_bus_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic        grant_d,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            last_gnt_d;
  logic [CW-1:0]   stall_cnt;
  logic            d_pend;
  logic            i_pend;
  logic            granted;
  logic            done;
  logic            enter_gnt;

  assign d_pend    = d_read | d_write;
  assign i_pend    = i_read;
  assign granted   = (state_q != IDLE);
  assign done      = granted & ~waitrequest;
  assign enter_gnt = (state_d != state_q) &&
                     (state_d != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_d <= 1'b0;
    end else begin
      state_q <= state_d;
      if (done && state_q == GNT_I && i_pend)
        last_gnt_d <= 1'b0;
      else if (done && state_q == GNT_D && d_pend)
        last_gnt_d <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_pend && i_pend)
          state_d = last_gnt_d ? GNT_I : GNT_D;
        else if (d_pend)
          state_d = GNT_D;
        else if (i_pend)
          state_d = GNT_I;
      end
      GNT_I: begin
        if (!i_pend)
          state_d = IDLE;
        else if (!waitrequest)
          state_d = d_pend ? GNT_D : IDLE;
      end
      GNT_D: begin
        if (!d_pend)
          state_d = IDLE;
        else if (!waitrequest)
          state_d = i_pend ? GNT_I : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_readdata = readdata;
  assign d_readdata = readdata;
  assign grant_d    = (state_q == GNT_D);

  always_comb begin
    address       = 32'h0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = 32'h0;
    byteenable    = 4'h0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    unique case (state_q)
      GNT_I: begin
        address       = i_address;
        read          = i_read;
        byteenable    = 4'hF;
        i_waitrequest = waitrequest;
      end
      GNT_D: begin
        address       = d_address;
        // read+write together is treated as a write
        read          = d_read & ~d_write;
        write         = d_write;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else if (enter_gnt) begin
      stall_cnt <= '0;
    end else if (granted && waitrequest &&
                 stall_cnt != CW'(TIMEOUT)) begin
      stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == CW'(TIMEOUT - 1))
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed bench for mips_cpu_bus_arbiter.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address = '0;
  logic        i_read = 1'b0;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = '0;
  logic [3:0]  d_byteenable = '0;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = '0;
  logic        grant_d;
  logic        timeout_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_address     (i_address),
    .i_read        (i_read),
    .i_waitrequest (i_waitrequest),
    .i_readdata    (i_readdata),
    .d_address     (d_address),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_writedata   (d_writedata),
    .d_byteenable  (d_byteenable),
    .d_waitrequest (d_waitrequest),
    .d_readdata    (d_readdata),
    .address       (address),
    .read          (read),
    .write         (write),
    .waitrequest   (waitrequest),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .grant_d       (grant_d),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_read = 0; d_read = 0; d_write = 0;
    waitrequest = 0;
    reset = 1;
    next();
    reset = 0;
  endtask

  initial begin
    // reset state
    samp();
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_addr", address, 0);
    check("rst_wdata", writedata, 0);
    check("rst_be", byteenable, 0);
    check("rst_gnt_d", grant_d, 0);
    check("rst_i_wait", i_waitrequest, 1);
    check("rst_d_wait", d_waitrequest, 1);
    check("rst_tmo", timeout_err, 0);
    next();
    reset = 0;

    // 1: single fetch
    i_address = 32'hBFC00000;
    i_read = 1;
    readdata = 32'h12345678;
    samp();
    check("t1_idle_read", read, 0);
    check("t1_idle_iwait", i_waitrequest, 1);
    next();
    samp();
    check("t1_read", read, 1);
    check("t1_addr", address, 32'hBFC00000);
    check("t1_iwait", i_waitrequest, 0);
    check("t1_rdata", i_readdata, 32'h12345678);
    check("t1_be", byteenable, 4'hF);
    check("t1_write", write, 0);
    next();
    i_read = 0;
    samp();
    check("t1_done_read", read, 0);
    check("t1_done_iwait", i_waitrequest, 1);

    // 2: simultaneous I and D after reset
    do_reset();
    i_address = 32'hBFC00004;
    i_read = 1;
    d_address = 32'h1000;
    d_write = 1;
    d_writedata = 32'hDEADBEEF;
    d_byteenable = 4'hF;
    next();
    samp();
    check("t2_gnt_d", grant_d, 1);
    check("t2_write", write, 1);
    check("t2_read", read, 0);
    check("t2_addr", address, 32'h1000);
    check("t2_wdata", writedata, 32'hDEADBEEF);
    check("t2_dwait", d_waitrequest, 0);
    check("t2_iwait", i_waitrequest, 1);
    next();
    d_write = 0;
    samp();
    check("t2_gnt_i", grant_d, 0);
    check("t2_i_read", read, 1);
    check("t2_i_write", write, 0);
    check("t2_i_addr", address, 32'hBFC00004);
    check("t2_i_iwait", i_waitrequest, 0);
    check("t2_i_dwait", d_waitrequest, 1);
    next();
    i_read = 0;
    samp();
    check("t2_idle", read, 0);

    // 3: D read stalled 3 cycles, I waiting
    d_address = 32'h2000;
    d_read = 1;
    d_byteenable = 4'h3;
    i_read = 1;
    readdata = 32'hCAFEF00D;
    waitrequest = 1;
    next();
    for (int k = 0; k < 4; k++) begin
      waitrequest = (k < 3);
      samp();
      check($sformatf("t3_dwait%0d", k),
            d_waitrequest, (k < 3) ? 1 : 0);
      check($sformatf("t3_iwait%0d", k),
            i_waitrequest, 1);
      check($sformatf("t3_addr%0d", k),
            address, 32'h2000);
      check($sformatf("t3_read%0d", k), read, 1);
      next();
    end
    d_read = 0;
    samp();
    check("t3_be_i", byteenable, 4'hF);
    check("t3_gnt_i", i_waitrequest, 0);
    check("t3_tmo", timeout_err, 0);
    next();
    i_read = 0;
    samp();
    check("t3_idle", read, 0);

    // 4: continuous requests alternate D,I,...
    i_read = 1;
    d_read = 1;
    waitrequest = 0;
    next();
    for (int k = 0; k < 6; k++) begin
      samp();
      check($sformatf("t4_gnt%0d", k),
            grant_d, (k % 2 == 0) ? 1 : 0);
      next();
    end
    i_read = 0;
    d_read = 0;
    samp();
    check("t4_drop_gnt", grant_d, 1);
    check("t4_drop_read", read, 0);
    next();
    samp();
    check("t4_idle_gnt", grant_d, 0);
    check("t4_no_err", timeout_err, 0);

    // 5: timeout after 4 stall cycles
    do_reset();
    i_address = 32'hBFC00008;
    i_read = 1;
    waitrequest = 1;
    next();
    for (int s = 1; s <= 4; s++) begin
      samp();
      check($sformatf("t5_tmo%0d", s),
            timeout_err, 0);
      next();
    end
    samp();
    check("t5_tmo_set", timeout_err, 1);
    check("t5_read", read, 1);
    next();
    waitrequest = 0;
    samp();
    check("t5_release", i_waitrequest, 0);
    next();
    i_read = 0;
    samp();
    check("t5_idle", read, 0);
    check("t5_sticky", timeout_err, 1);
    next();
    samp();
    check("t5_sticky2", timeout_err, 1);
    do_reset();
    samp();
    check("t5_cleared", timeout_err, 0);

    // 6: async reset during D write stall
    next();
    d_address = 32'h3000;
    d_write = 1;
    d_writedata = 32'h55AA55AA;
    waitrequest = 1;
    next();
    samp();
    check("t6_write", write, 1);
    check("t6_gnt_d", grant_d, 1);
    #2;
    reset = 1;
    #1;
    check("t6_rst_write", write, 0);
    check("t6_rst_gnt", grant_d, 0);
    check("t6_rst_dwait", d_waitrequest, 1);
    d_write = 0;
    next();
    reset = 0;
    samp();
    check("t6_idle", write, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
